// File: rtl/regfile_wr_arb_if.sv
// Register-file write-port bundle: pipeline writeback, button-unit request,
// arbitrated register-file write and arbiter status.
interface regfile_wr_arb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wb_wr_reg;
    logic [ADDR_W-1:0] wb_rd_addr;
    logic [DATA_W-1:0] wb_rd_data;
    logic              btn_valid;
    logic [ADDR_W-1:0] btn_addr;
    logic [DATA_W-1:0] btn_data;
    logic              btn_ready;
    logic              pipe_stall;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [7:0]        starve_cnt;
    logic              wb_conflict;

    // Requesters and register-file side.
    modport master (
        output wb_wr_reg, wb_rd_addr, wb_rd_data,
        output btn_valid, btn_addr, btn_data,
        input  btn_ready, pipe_stall,
        input  rf_we, rf_waddr, rf_wdata,
        input  starve_cnt, wb_conflict
    );

    // Arbiter side.
    modport slave (
        input  wb_wr_reg, wb_rd_addr, wb_rd_data,
        input  btn_valid, btn_addr, btn_data,
        output btn_ready, pipe_stall,
        output rf_we, rf_waddr, rf_wdata,
        output starve_cnt, wb_conflict
    );
endinterface

// File: rtl/regfile_wr_arb.sv
// Register-file write-port arbiter: pipeline writeback wins, button unit waits.
// Define REGFILE_WR_ARB_STARVE_GUARD_EN to enable the anti-starvation FORCE state.
module regfile_wr_arb #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    regfile_wr_arb_if.slave  bus
);
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [7:0]        blk_cnt_reg, blk_cnt_next;
    logic              both_req;
    logic              xfer;
    logic              wr_en_sel;
    logic [ADDR_W-1:0] wr_addr_sel;
    logic [DATA_W-1:0] wr_data_sel;
    logic              rf_we_reg;
    logic [ADDR_W-1:0] rf_waddr_reg;
    logic [DATA_W-1:0] rf_wdata_reg;

    assign both_req      = bus.btn_valid & bus.wb_wr_reg;
    assign xfer          = bus.btn_valid & ~bus.wb_wr_reg;
    assign bus.btn_ready = xfer;

`ifdef REGFILE_WR_ARB_STARVE_GUARD_EN
    logic       enter_force;
    logic [7:0] starve_cnt_reg;
    logic       conflict_reg;
`endif

    always_comb begin
        state_next   = state_reg;
        blk_cnt_next = blk_cnt_reg;
`ifdef REGFILE_WR_ARB_STARVE_GUARD_EN
        enter_force  = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (both_req) begin
                    state_next   = WAIT;
                    blk_cnt_next = 8'd1;
                end else begin
                    blk_cnt_next = 8'd0;
                end
            end
            WAIT: begin
                if (both_req) begin
`ifdef REGFILE_WR_ARB_STARVE_GUARD_EN
                    blk_cnt_next = blk_cnt_reg + 8'd1;
                    if (blk_cnt_next == LIMIT) begin
                        state_next  = FORCE;
                        enter_force = 1'b1;
                    end
`else
                    if (blk_cnt_reg != LIMIT) begin
                        blk_cnt_next = blk_cnt_reg + 8'd1;
                    end
`endif
                end else begin
                    // Either the button transferred or it withdrew.
                    state_next   = IDLE;
                    blk_cnt_next = 8'd0;
                end
            end
`ifdef REGFILE_WR_ARB_STARVE_GUARD_EN
            FORCE: begin
                if (!both_req) begin
                    state_next   = IDLE;
                    blk_cnt_next = 8'd0;
                end
            end
`endif
            default: begin
                state_next   = IDLE;
                blk_cnt_next = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            blk_cnt_reg <= 8'd0;
        end else begin
            state_reg   <= state_next;
            blk_cnt_reg <= blk_cnt_next;
        end
    end

    // Write source select; register 0 is never written but the handshake still completes.
    always_comb begin
        wr_en_sel   = 1'b0;
        wr_addr_sel = bus.wb_rd_addr;
        wr_data_sel = bus.wb_rd_data;
        if (bus.wb_wr_reg) begin
            wr_en_sel = (bus.wb_rd_addr != '0);
        end else if (xfer) begin
            wr_addr_sel = bus.btn_addr;
            wr_data_sel = bus.btn_data;
            wr_en_sel   = (bus.btn_addr != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_reg    <= 1'b0;
            rf_waddr_reg <= '0;
            rf_wdata_reg <= '0;
        end else begin
            rf_we_reg <= wr_en_sel;
            if (wr_en_sel) begin
                rf_waddr_reg <= wr_addr_sel;
                rf_wdata_reg <= wr_data_sel;
            end
        end
    end

    assign bus.rf_we    = rf_we_reg;
    assign bus.rf_waddr = rf_waddr_reg;
    assign bus.rf_wdata = rf_wdata_reg;

`ifdef REGFILE_WR_ARB_STARVE_GUARD_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_reg <= 8'd0;
            conflict_reg   <= 1'b0;
        end else begin
            if (enter_force && starve_cnt_reg != 8'hFF) begin
                starve_cnt_reg <= starve_cnt_reg + 8'd1;
            end
            // Pipeline ignored the stall request; it still wins the port.
            if (state_reg == FORCE && bus.wb_wr_reg) begin
                conflict_reg <= 1'b1;
            end
        end
    end

    assign bus.pipe_stall  = (state_reg == FORCE);
    assign bus.starve_cnt  = starve_cnt_reg;
    assign bus.wb_conflict = conflict_reg;
`else
    assign bus.pipe_stall  = 1'b0;
    assign bus.starve_cnt  = 8'd0;
    assign bus.wb_conflict = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_wr_arb.sv
// Scoreboard bench for regfile_wr_arb: expected register writes are queued as
// stimulus is driven and retired as rf_we pulses appear.
module tb_regfile_wr_arb;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

`ifdef REGFILE_WR_ARB_STARVE_GUARD_EN
    localparam logic GUARD = 1'b1;
`else
    localparam logic GUARD = 1'b0;
`endif

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    wr_t  exp_q[$];

    regfile_wr_arb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_wr_arb #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .STARVE_LIMIT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of requests and queue the write the arbiter must produce.
    task automatic drive(input logic wb, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                         input logic bv, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd);
        wr_t e;
        bus.wb_wr_reg  = wb;
        bus.wb_rd_addr = wa;
        bus.wb_rd_data = wd;
        bus.btn_valid  = bv;
        bus.btn_addr   = ba;
        bus.btn_data   = bd;
        if (!rst) begin
            if (wb) begin
                if (wa != '0) begin
                    e.addr = wa;
                    e.data = wd;
                    exp_q.push_back(e);
                end
            end else if (bv && ba != '0) begin
                e.addr = ba;
                e.data = bd;
                exp_q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (bus.rf_we === 1'b1) begin
            $display("write r%0d <= %0d", bus.rf_waddr, bus.rf_wdata);
            if (exp_q.size() == 0) begin
                chk("rf_we_unexpected", 32'(bus.rf_we), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rf_waddr", 32'(bus.rf_waddr), 32'(e.addr));
                chk("rf_wdata", bus.rf_wdata, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
        chk("rst_rf_waddr", 32'(bus.rf_waddr), 32'd0);
        chk("rst_rf_wdata", bus.rf_wdata, 32'd0);
        chk("rst_pipe_stall", 32'(bus.pipe_stall), 32'd0);
        chk("rst_starve_cnt", 32'(bus.starve_cnt), 32'd0);
        chk("rst_wb_conflict", 32'(bus.wb_conflict), 32'd0);

        // Button write alone, then hold of address/data on an idle cycle.
        drive(1'b0, '0, '0, 1'b1, 5'd3, 32'd42);
        chk("btn_alone_ready", 32'(bus.btn_ready), 32'd1);
        tick();
        idle();
        tick();
        chk("idle_rf_we", 32'(bus.rf_we), 32'd0);
        chk("hold_rf_waddr", 32'(bus.rf_waddr), 32'd3);
        chk("hold_rf_wdata", bus.rf_wdata, 32'd42);

        // Simultaneous requests: pipeline first, button on the next free cycle.
        drive(1'b1, 5'd5, 32'd7, 1'b1, 5'd6, 32'd9);
        chk("simul_ready", 32'(bus.btn_ready), 32'd0);
        tick();
        drive(1'b0, '0, '0, 1'b1, 5'd6, 32'd9);
        chk("simul_retry_ready", 32'(bus.btn_ready), 32'd1);
        chk("wait_pipe_stall", 32'(bus.pipe_stall), 32'd0);
        tick();
        idle();
        tick();

        // Starvation: eight blocked cycles push the arbiter into FORCE.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 5'd10, 32'(100 + i), 1'b1, 5'd11, 32'd55);
            chk("starve_ready", 32'(bus.btn_ready), 32'd0);
            chk("starve_no_stall", 32'(bus.pipe_stall), 32'd0);
            tick();
        end
        drive(1'b0, '0, '0, 1'b1, 5'd11, 32'd55);
        chk("force_pipe_stall", 32'(bus.pipe_stall), 32'(GUARD));
        chk("force_starve_cnt", 32'(bus.starve_cnt), 32'(GUARD));
        chk("force_ready", 32'(bus.btn_ready), 32'd1);
        tick();
        idle();
        chk("force_exit_stall", 32'(bus.pipe_stall), 32'd0);
        tick();

        // Address 0 from either source never asserts rf_we.
        drive(1'b0, '0, '0, 1'b1, 5'd0, 32'd99);
        chk("a0_btn_ready", 32'(bus.btn_ready), 32'd1);
        tick();
        chk("a0_btn_we", 32'(bus.rf_we), 32'd0);
        drive(1'b1, 5'd0, 32'd77, 1'b1, 5'd4, 32'd13);
        chk("a0_wb_blocks", 32'(bus.btn_ready), 32'd0);
        tick();
        chk("a0_wb_we", 32'(bus.rf_we), 32'd0);
        drive(1'b0, '0, '0, 1'b1, 5'd4, 32'd13);
        chk("a0_retry_ready", 32'(bus.btn_ready), 32'd1);
        tick();
        idle();
        tick();

        // Reset while in FORCE abandons the pending button write.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 5'd12, 32'(300 + i), 1'b1, 5'd13, 32'd66);
            tick();
        end
        chk("rstf_pipe_stall_pre", 32'(bus.pipe_stall), 32'(GUARD));
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b1, 5'd13, 32'd66);
        chk("rstf_ready", 32'(bus.btn_ready), 32'd1);
        tick();
        rst = 1'b0;
        idle();
        chk("rstf_pipe_stall", 32'(bus.pipe_stall), 32'd0);
        chk("rstf_starve_cnt", 32'(bus.starve_cnt), 32'd0);
        chk("rstf_rf_we", 32'(bus.rf_we), 32'd0);
        tick();
        chk("rstf_rf_we_after", 32'(bus.rf_we), 32'd0);

        // Pipeline ignores the stall: it wins and the conflict flag sticks.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 5'd14, 32'(500 + i), 1'b1, 5'd15, 32'd88);
            tick();
        end
        drive(1'b1, 5'd14, 32'd200, 1'b1, 5'd15, 32'd88);
        chk("viol_pipe_stall", 32'(bus.pipe_stall), 32'(GUARD));
        chk("viol_ready", 32'(bus.btn_ready), 32'd0);
        tick();
        chk("viol_conflict", 32'(bus.wb_conflict), 32'(GUARD));
        drive(1'b0, '0, '0, 1'b1, 5'd15, 32'd88);
        tick();
        idle();
        repeat (3) tick();
        chk("viol_conflict_held", 32'(bus.wb_conflict), 32'(GUARD));
        chk("viol_starve_cnt", 32'(bus.starve_cnt), 32'(GUARD));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("viol_conflict_rst", 32'(bus.wb_conflict), 32'd0);
        repeat (2) tick();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
